// File: rtl/shifter_rr_arbiter.sv
// ============================================================================
// Module   : shifter_rr_arbiter
// Purpose  : Two-requester round-robin front end sharing one 32-bit rotator,
//            with a single-entry registered result carrying the requester ID.
//            Optional per-channel saturating grant counters: SHARB_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shifter_rr_arbiter #(
  parameter int CNT_W     = 16,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SHARB_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
`endif
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [4:0]       req0_amt,
  input  logic             req0_lr,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [4:0]       req1_amt,
  input  logic             req1_lr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_id
);

  // Rotating a doubled word keeps every bit; amt=0 falls out naturally.
  function automatic logic [31:0] rotate32(input logic [31:0] a,
                                           input logic [4:0]  amt,
                                           input logic        lr);
    logic [63:0] dbl;
    logic [63:0] sh;
    dbl = {a, a};
    if (lr) begin
      sh = dbl << amt;
      return sh[63:32];
    end else begin
      sh = dbl >> amt;
      return sh[31:0];
    end
  endfunction

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_y_q,     out_y_d;
  logic        out_id_q,    out_id_d;
  logic        last_q,      last_d;

  logic        w_can_accept;
  logic        w_any_valid;
  logic        w_grant_id;
  logic        w_xfer;
  logic [31:0] w_sel_a;
  logic [4:0]  w_sel_amt;
  logic        w_sel_lr;

  assign w_can_accept = ~out_valid_q | out_ready;
  assign w_any_valid  = req0_valid | req1_valid;
  // On contention the channel that did not win last time goes next.
  assign w_grant_id   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign w_xfer       = ~rst & w_can_accept & w_any_valid;

  assign req0_ready = w_xfer & ~w_grant_id;
  assign req1_ready = w_xfer &  w_grant_id;

  assign w_sel_a   = w_grant_id ? req1_a   : req0_a;
  assign w_sel_amt = w_grant_id ? req1_amt : req0_amt;
  assign w_sel_lr  = w_grant_id ? req1_lr  : req0_lr;

  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_id_d    = out_id_q;
    last_d      = last_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_y_d     = rotate32(w_sel_a, w_sel_amt, w_sel_lr);
      out_id_d    = w_grant_id;
      last_d      = w_grant_id;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= 32'd0;
      out_id_q    <= 1'b0;
      last_q      <= ~INIT_PRIO;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_id_q    <= out_id_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;

`ifdef SHARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (req0_valid & req0_ready & ~(&cnt0_q)) cnt0_d = cnt0_q + 1'b1;
      if (req1_valid & req1_ready & ~(&cnt1_q)) cnt1_d = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  logic [CNT_W-1:0] w_cnt_unused;
  assign w_cnt_unused = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shifter_rr_arbiter.sv
// ============================================================================
// Module   : tb_shifter_rr_arbiter
// Purpose  : Directed self-checking bench for shifter_rr_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shifter_rr_arbiter;

  localparam int TB_CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_lr;
  logic [31:0] req0_a;
  logic [4:0]  req0_amt;
  logic        req1_valid, req1_ready, req1_lr;
  logic [31:0] req1_a;
  logic [4:0]  req1_amt;
  logic        out_valid, out_ready, out_id;
  logic [31:0] out_y;
`ifdef SHARB_STATS_EN
  logic                stats_clr;
  logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shifter_rr_arbiter #(.CNT_W(TB_CNT_W), .INIT_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SHARB_STATS_EN
    .stats_clr  (stats_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_amt   (req0_amt),
    .req0_lr    (req0_lr),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_amt   (req1_amt),
    .req1_lr    (req1_lr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_id     (out_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [4:0] amt, input logic lr);
    req0_valid = v; req0_a = a; req0_amt = amt; req0_lr = lr;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [4:0] amt, input logic lr);
    req1_valid = v; req1_a = a; req1_amt = amt; req1_lr = lr;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
`ifdef SHARB_STATS_EN
    stats_clr = 1'b0;
`endif
    set0(1'b1, 32'h0, 5'd0, 1'b0);
    set1(1'b1, 32'h0, 5'd0, 1'b0);
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_out_id", {31'd0, out_id}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);

    // Single job on channel 0
    rst = 1'b0;
    set1(1'b0, 32'h0, 5'd0, 1'b0);
    set0(1'b1, 32'hDEADBEEF, 5'd1, 1'b0);
    #1;
    chk("single_ready0", {31'd0, req0_ready}, 32'd1);
    chk("single_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_y", out_y, 32'hEF56DF77);
    chk("single_id", {31'd0, out_id}, 32'd0);
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_y_hold", out_y, 32'hEF56DF77);

    // Contention after a fresh reset: 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    set0(1'b1, 32'h12345678, 5'd4, 1'b0);
    set1(1'b1, 32'hAABBCCDD, 5'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("cont_valid", {31'd0, out_valid}, 32'd1);
      chk("cont_id", {31'd0, out_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("cont_y", out_y, (i % 2 == 0) ? 32'h81234567 : 32'hBBCCDDAA);
    end

    // Backpressure for 3 cycles, then drain + accept together
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_y", out_y, 32'hBBCCDDAA);
      chk("bp_id", {31'd0, out_id}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready0", {31'd0, req0_ready}, 32'd1);
    step();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_release_y", out_y, 32'h81234567);
    chk("bp_release_id", {31'd0, out_id}, 32'd0);

    // Rotation boundaries on channel 1
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    set1(1'b1, 32'hCAFEBABE, 5'd0, 1'b1);
    step();
    chk("bnd_amt0_left", out_y, 32'hCAFEBABE);
    chk("bnd_id", {31'd0, out_id}, 32'd1);
    set1(1'b1, 32'hCAFEBABE, 5'd0, 1'b0);
    step();
    chk("bnd_amt0_right", out_y, 32'hCAFEBABE);
    set1(1'b1, 32'hFACEB00C, 5'd16, 1'b1);
    step();
    chk("bnd_amt16_left", out_y, 32'hB00CFACE);
    set1(1'b1, 32'h00000001, 5'd31, 1'b0);
    step();
    chk("bnd_amt31_right", out_y, 32'h00000002);

    // Reset mid-backpressure; ch0 had the last grant, reset must restore ch0 priority
    set1(1'b0, 32'h0, 5'd0, 1'b0);
    set0(1'b1, 32'h000000FF, 5'd4, 1'b1);
    step();
    chk("pre_rst_y", out_y, 32'h00000FF0);
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    out_ready = 1'b0;
    step();
    chk("pre_rst_hold_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    chk("midbp_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("midbp_rst_y", out_y, 32'd0);
    chk("midbp_rst_id", {31'd0, out_id}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    set0(1'b1, 32'h12345678, 5'd4, 1'b0);
    set1(1'b1, 32'hAABBCCDD, 5'd8, 1'b1);
    #1;
    chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    chk("post_rst_id", {31'd0, out_id}, 32'd0);
    chk("post_rst_y", out_y, 32'h81234567);

`ifdef SHARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt_rst0", {28'd0, grant_cnt0}, 32'd0);
    chk("cnt_rst1", {28'd0, grant_cnt1}, 32'd0);
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("cnt_sat1", {28'd0, grant_cnt1}, 32'hF);
    chk("cnt_idle0", {28'd0, grant_cnt0}, 32'd0);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("cnt_clr1", {28'd0, grant_cnt1}, 32'd0);
    step();
    chk("cnt_after_clr1", {28'd0, grant_cnt1}, 32'd1);
`endif

    set0(1'b0, 32'h0, 5'd0, 1'b0);
    set1(1'b0, 32'h0, 5'd0, 1'b0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
